// File: rtl/tcp_tx_arbiter.sv
// Round-robin arbiter with RST-flag priority that shares one registered TCP packet link
// between NUM_REQ requesters.
module tcp_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PKT_W   = 224,
  parameter int unsigned RST_BIT = 114
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*PKT_W-1:0]   req_packet,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [PKT_W-1:0]           out_packet,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [15:0]                pkt_count
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [IdW-1:0]     gid_q, gid_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic [15:0]        cnt_q, cnt_d;

  logic [NUM_REQ-1:0] urgent;
  logic [NUM_REQ-1:0] cand;
  logic [IdW-1:0]     win;
  logic               found;
  logic               load;
  logic               grant;

  always_comb begin
    urgent = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      urgent[i] = req_valid[i] & req_packet[i*PKT_W + RST_BIT];
    end
    // RST packets pre-empt normal traffic, but still rotate among themselves from ptr.
    cand  = (|urgent) ? urgent : req_valid;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = IdW'(idx);
      end
    end
  end

  always_comb begin
    load  = (state_q == StEmpty) || out_ready;
    grant = load && found && !rst;

    req_ready = '0;
    state_d   = state_q;
    ptr_d     = ptr_q;
    gid_d     = gid_q;
    pkt_d     = pkt_q;
    cnt_d     = cnt_q;

    if ((state_q == StFull) && out_ready) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (grant) begin
      req_ready[win] = 1'b1;
      state_d        = StFull;
      gid_d          = win;
      pkt_d          = req_packet[win*PKT_W +: PKT_W];
      ptr_d          = (win == IdW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else if ((state_q == StFull) && out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      gid_q   <= '0;
      pkt_q   <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = (state_q == StFull);
  assign out_packet = pkt_q;
  assign grant_id   = gid_q;
  assign pkt_count  = cnt_q;

endmodule
